// File: rtl/mux_arb2x1_if.sv
// mux_arb2x1_if
// Bundles the two input streams and the merged output stream of the
// 2:1 arbitrating mux into one interface.
//
// Signals
//   x0_valid / x0_data / x0_ready : input stream 0 (valid/ready handshake)
//   x1_valid / x1_data / x1_ready : input stream 1 (valid/ready handshake)
//   f_valid / f / f_ready         : merged output stream
//   s                             : source stream of the word currently in f
//
// Modports
//   slave  : the arbiter side (consumes x0/x1, produces f)
//   master : the environment side (produces x0/x1, consumes f)
interface mux_arb2x1_if #(
    parameter int N = 4
);
    logic         x0_valid;
    logic [N-1:0] x0_data;
    logic         x0_ready;
    logic         x1_valid;
    logic [N-1:0] x1_data;
    logic         x1_ready;
    logic         f_valid;
    logic [N-1:0] f;
    logic         f_ready;
    logic         s;

    modport slave (
        input  x0_valid, x0_data, x1_valid, x1_data, f_ready,
        output x0_ready, x1_ready, f_valid, f, s
    );

    modport master (
        output x0_valid, x0_data, x1_valid, x1_data, f_ready,
        input  x0_ready, x1_ready, f_valid, f, s
    );
endinterface

// File: rtl/mux_arb2x1.sv
// mux_arb2x1
// Merges two valid/ready streams into one through a single-entry output
// register. A combinational round-robin grant picks which stream feeds the
// register; ties go to the stream that was not served most recently, so two
// continuously valid streams alternate word by word.
//
// Ports
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : mux_arb2x1_if.slave carrying x0/x1 input streams, the f output
//          stream and the source select s
module mux_arb2x1 #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    mux_arb2x1_if.slave    bus
);

    logic         load;
    logic         grant0;
    logic         grant1;
    logic         take0;
    logic         take1;

    logic         f_valid_q, f_valid_d;
    logic [N-1:0] f_q, f_d;
    logic         s_q, s_d;
    logic         last_q, last_d;

    // Grant decision and handshake. The register can take a new word when
    // it is empty or being drained this cycle. On a tie, last_q=1 means
    // stream 1 was served last, so stream 0 wins. Nothing is accepted while
    // reset is asserted. Readys never look at either stream's data.
    always_comb begin
        load   = ~f_valid_q | bus.f_ready;
        grant0 = bus.x0_valid & (~bus.x1_valid | last_q);
        grant1 = bus.x1_valid & (~bus.x0_valid | ~last_q);
        take0  = ~rst & load & grant0;
        take1  = ~rst & load & grant1;
    end

    // Next state of the output register. A load replaces the held word in
    // the same edge as it drains, so there is no bubble. A drain without a
    // load only clears the valid flag; f and s keep their last values.
    always_comb begin
        f_valid_d = f_valid_q;
        f_d       = f_q;
        s_d       = s_q;
        last_d    = last_q;
        if (take0 | take1) begin
            f_valid_d = 1'b1;
            f_d       = take1 ? bus.x1_data : bus.x0_data;
            s_d       = take1;
            last_d    = take1;
        end else if (bus.f_ready) begin
            f_valid_d = 1'b0;
        end
    end

    // State registers. Reset discards any held word and primes last_q to 1
    // so the first tie after reset goes to stream 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_valid_q <= 1'b0;
            f_q       <= '0;
            s_q       <= 1'b0;
            last_q    <= 1'b1;
        end else begin
            f_valid_q <= f_valid_d;
            f_q       <= f_d;
            s_q       <= s_d;
            last_q    <= last_d;
        end
    end

    assign bus.x0_ready = take0;
    assign bus.x1_ready = take1;
    assign bus.f_valid  = f_valid_q;
    assign bus.f        = f_q;
    assign bus.s        = s_q;

endmodule

// File: tb/tb_mux_arb2x1.sv
// tb_mux_arb2x1
// Self-checking bench for mux_arb2x1 (N=4). Directed scenarios followed by
// a long randomized run with per-stream scoreboards and a fairness monitor.
module tb_mux_arb2x1;

    logic clk;
    logic rst;

    int checks;
    int failures;

    // Reference state of the output register and arbitration history.
    logic       mValid;
    logic [3:0] mF;
    logic       mS;
    logic       mLast;

    // Readys observed in the most recent cycle, for directed checks.
    logic obsR0;
    logic obsR1;

    // Scoreboard: words accepted per stream, awaiting the output.
    logic [3:0] sentQ0[$];
    logic [3:0] sentQ1[$];
    bit         sbOn;

    mux_arb2x1_if #(.N(4)) bus ();

    mux_arb2x1 #(.N(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value to its expectation and count the result.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive all DUT inputs for the coming cycle.
    task automatic applyStimulus(input logic r, input logic v0, input logic [3:0] d0,
                                 input logic v1, input logic [3:0] d1, input logic fr);
        rst          = r;
        bus.x0_valid = v0;
        bus.x0_data  = d0;
        bus.x1_valid = v1;
        bus.x1_data  = d1;
        bus.f_ready  = fr;
    endtask

    // One full clock cycle: drive, check readys against the reference,
    // consume any drained word into the scoreboard, clock, advance the
    // reference and check the registered outputs.
    task automatic runCycle(input logic r, input logic v0, input logic [3:0] d0,
                            input logic v1, input logic [3:0] d1, input logic fr);
        logic       expR0;
        logic       expR1;
        logic [3:0] popped;
        applyStimulus(r, v0, d0, v1, d1, fr);
        #1;
        expR0 = 1'b0;
        expR1 = 1'b0;
        // A word can enter when the register is empty or leaving now;
        // on a tie the stream that was not served last wins.
        if (!r && (!mValid || fr)) begin
            if (v0 && v1) begin
                if (mLast == 1'b1) expR0 = 1'b1;
                else               expR1 = 1'b1;
            end else if (v0) begin
                expR0 = 1'b1;
            end else if (v1) begin
                expR1 = 1'b1;
            end
        end
        obsR0 = bus.x0_ready;
        obsR1 = bus.x1_ready;
        checkOutput("x0_ready", {31'd0, obsR0}, {31'd0, expR0});
        checkOutput("x1_ready", {31'd0, obsR1}, {31'd0, expR1});
        if (sbOn && !r && bus.f_valid === 1'b1 && fr) begin
            if (bus.s === 1'b1) begin
                checkOutput("sb1_nonempty", {31'd0, sentQ1.size() > 0}, 32'd1);
                if (sentQ1.size() > 0) begin
                    popped = sentQ1.pop_front();
                    checkOutput("sb1_order", {28'd0, bus.f}, {28'd0, popped});
                end
            end else begin
                checkOutput("sb0_nonempty", {31'd0, sentQ0.size() > 0}, 32'd1);
                if (sentQ0.size() > 0) begin
                    popped = sentQ0.pop_front();
                    checkOutput("sb0_order", {28'd0, bus.f}, {28'd0, popped});
                end
            end
        end
        @(posedge clk);
        if (r) begin
            mValid = 1'b0;
            mF     = 4'h0;
            mS     = 1'b0;
            mLast  = 1'b1;
        end else if (expR0 || expR1) begin
            mValid = 1'b1;
            mS     = expR1;
            mF     = expR1 ? d1 : d0;
            mLast  = expR1;
        end else if (fr) begin
            mValid = 1'b0;
        end
        #1;
        checkOutput("f_valid", {31'd0, bus.f_valid}, {31'd0, mValid});
        checkOutput("f",       {28'd0, bus.f},       {28'd0, mF});
        checkOutput("s",       {31'd0, bus.s},       {31'd0, mS});
    endtask

    // Directed scenarios, then randomized traffic with scoreboards.
    initial begin
        logic [3:0] seqF[4];
        logic       seqS[4];
        bit         pend0, pend1;
        logic [3:0] data0, data1;
        int         wait0, wait1;
        int         frPct;
        int         drainBudget;

        checks   = 0;
        failures = 0;
        sbOn     = 1'b0;
        mValid   = 1'b0;
        mF       = 4'h0;
        mS       = 1'b0;
        mLast    = 1'b1;

        // Reset with traffic present: nothing may be accepted.
        runCycle(1'b1, 1'b1, 4'hA, 1'b1, 4'hC, 1'b1);
        runCycle(1'b1, 1'b1, 4'hA, 1'b1, 4'hC, 1'b1);
        checkOutput("rst_x0_ready", {31'd0, obsR0}, 32'd0);
        checkOutput("rst_f_valid", {31'd0, bus.f_valid}, 32'd0);
        checkOutput("rst_f", {28'd0, bus.f}, 32'd0);

        // Single stream-0 word: accepted same cycle, visible next cycle.
        runCycle(1'b0, 1'b1, 4'hA, 1'b0, 4'h0, 1'b1);
        checkOutput("single_x0_ready", {31'd0, obsR0}, 32'd1);
        checkOutput("single_f_valid", {31'd0, bus.f_valid}, 32'd1);
        checkOutput("single_f", {28'd0, bus.f}, 32'hA);
        checkOutput("single_s", {31'd0, bus.s}, 32'd0);

        // Both streams valid at full rate: strict alternation from stream 0.
        runCycle(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        seqF[0] = 4'h3; seqF[1] = 4'hC; seqF[2] = 4'h3; seqF[3] = 4'hC;
        seqS[0] = 1'b0; seqS[1] = 1'b1; seqS[2] = 1'b0; seqS[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            runCycle(1'b0, 1'b1, 4'h3, 1'b1, 4'hC, 1'b1);
            checkOutput("alt_f_valid", {31'd0, bus.f_valid}, 32'd1);
            checkOutput("alt_f", {28'd0, bus.f}, {28'd0, seqF[i]});
            checkOutput("alt_s", {31'd0, bus.s}, {31'd0, seqS[i]});
        end

        // Backpressure: full register holds, readys low, then drain+load.
        runCycle(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        runCycle(1'b0, 1'b1, 4'h5, 1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            runCycle(1'b0, 1'b1, 4'h6, 1'b1, 4'hC, 1'b0);
            checkOutput("full_x0_ready", {31'd0, obsR0}, 32'd0);
            checkOutput("full_x1_ready", {31'd0, obsR1}, 32'd0);
            checkOutput("full_f", {28'd0, bus.f}, 32'h5);
            checkOutput("full_s", {31'd0, bus.s}, 32'd0);
        end
        runCycle(1'b0, 1'b1, 4'h6, 1'b1, 4'hC, 1'b1);
        checkOutput("nobubble_x1_ready", {31'd0, obsR1}, 32'd1);
        checkOutput("nobubble_f_valid", {31'd0, bus.f_valid}, 32'd1);
        checkOutput("nobubble_f", {28'd0, bus.f}, 32'hC);

        // Drain with no new input: valid drops, data retained.
        runCycle(1'b0, 1'b1, 4'h7, 1'b0, 4'h0, 1'b1);
        runCycle(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        checkOutput("drain_f_valid", {31'd0, bus.f_valid}, 32'd0);
        checkOutput("drain_f", {28'd0, bus.f}, 32'h7);

        // Mid-operation reset discards the held word; next tie goes to 0.
        runCycle(1'b0, 1'b0, 4'h0, 1'b1, 4'hF, 1'b1);
        checkOutput("pre_rst_f", {28'd0, bus.f}, 32'hF);
        runCycle(1'b1, 1'b1, 4'h1, 1'b1, 4'h2, 1'b0);
        checkOutput("midrst_f_valid", {31'd0, bus.f_valid}, 32'd0);
        checkOutput("midrst_f", {28'd0, bus.f}, 32'h0);
        checkOutput("midrst_s", {31'd0, bus.s}, 32'd0);
        runCycle(1'b0, 1'b1, 4'h3, 1'b1, 4'hC, 1'b1);
        checkOutput("postrst_tie_x0", {31'd0, obsR0}, 32'd1);
        checkOutput("postrst_f", {28'd0, bus.f}, 32'h3);

        // Randomized traffic: sources hold a word until it is accepted.
        runCycle(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        sbOn  = 1'b1;
        pend0 = 1'b0;
        pend1 = 1'b0;
        data0 = 4'h0;
        data1 = 4'h0;
        wait0 = 0;
        wait1 = 0;
        for (int i = 0; i < 10000; i++) begin
            case ((i / 500) % 4)
                0:       frPct = 80;
                1:       frPct = 40;
                2:       frPct = 100;
                default: frPct = 15;
            endcase
            if (!pend0 && $urandom_range(0, 3) != 0) begin
                pend0 = 1'b1;
                data0 = 4'($urandom_range(0, 15));
            end
            if (!pend1 && $urandom_range(0, 3) != 0) begin
                pend1 = 1'b1;
                data1 = 4'($urandom_range(0, 15));
            end
            runCycle(1'b0, pend0, data0, pend1, data1, $urandom_range(0, 99) < frPct);
            if (pend0 && obsR0 === 1'b1) begin
                sentQ0.push_back(data0);
                pend0 = 1'b0;
                wait0 = 0;
            end
            if (pend1 && obsR1 === 1'b1) begin
                sentQ1.push_back(data1);
                pend1 = 1'b0;
                wait1 = 0;
            end
            if (pend0 && obsR1 === 1'b1) begin
                wait0++;
                checkOutput("fair_wait0", {31'd0, wait0 <= 1}, 32'd1);
            end
            if (pend1 && obsR0 === 1'b1) begin
                wait1++;
                checkOutput("fair_wait1", {31'd0, wait1 <= 1}, 32'd1);
            end
        end

        // Drain the last held word, then nothing may remain outstanding.
        drainBudget = 0;
        while (bus.f_valid === 1'b1 && drainBudget < 8) begin
            runCycle(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
            drainBudget++;
        end
        checkOutput("final_f_valid", {31'd0, bus.f_valid}, 32'd0);
        checkOutput("sb0_empty", sentQ0.size(), 32'd0);
        checkOutput("sb1_empty", sentQ1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
